// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants for the unpipelined core.
//   - MIPS opcode and R-type funct encodings for the supported subset
//   - aluOp encodings driven to the ALU
//   - decode_ctrl FSM state encoding
//   - helpers that classify an opcode/funct pair
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } stateT;

    function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: isLegal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                                (fn == FN_OR)  || (fn == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:
                isLegal = 1'b1;
            default:  isLegal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] aluOpFor(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB:  aluOpFor = ALU_SUB;
                    FN_AND:  aluOpFor = ALU_AND;
                    FN_OR:   aluOpFor = ALU_OR;
                    FN_SLT:  aluOpFor = ALU_SLT;
                    default: aluOpFor = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE: aluOpFor = ALU_SUB;
            OP_ANDI:        aluOpFor = ALU_AND;
            OP_ORI:         aluOpFor = ALU_OR;
            OP_LUI:         aluOpFor = ALU_LUI;
            default:        aluOpFor = ALU_ADD;
        endcase
    endfunction

    // Immediate-operand instructions feed imm_ext into ALU port B.
    function automatic logic usesImm(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: usesImm = 1'b1;
            default: usesImm = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_extend.sv
// imm_extend: combinational immediate extension selected by opcode.
//   opcode : instruction opcode field
//   imm    : raw 16-bit immediate field
//   immExt : sign-extended (arith/mem/branch), zero-extended (logical),
//            or upper-placed (lui) immediate; 0 for other opcodes
module imm_extend
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] immExt
);

    always_comb begin
        immExt = '0;
        case (opcode)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: immExt = DATA_W'($signed(imm));
            OP_ANDI, OP_ORI:                       immExt = DATA_W'(imm);
            OP_LUI:                                immExt = DATA_W'({imm, 16'h0000});
            default:                               immExt = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: multi-cycle decode/control sequencer, one instruction in flight.
//   Clk, Rst                 : rising-edge clock, async active-low reset
//   instr_valid/instr        : instruction from fetch, accepted when instr_ready
//   mem_done                 : data memory access complete (sampled in MEM only)
//   readReg1/2, writeReg     : register file addresses, valid from EXEC through WB
//   regWrite, writeEnable    : WB strobes (regWrite suppressed for register 0)
//   aluOp, aluSrc, imm_ext   : ALU controls and extended immediate
//   memRead/Write, memToReg  : data memory controls
//   branch_eq/ne, jump       : single-cycle pulses during EXEC
//   jump_target              : instr[25:0]
//   illegal, retired         : sticky bad-instruction flag, retired count
// All outputs are registered and change on the edge that enters a state.
module decode_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    input  logic              mem_done,
    output logic [REG_AW-1:0] readReg1,
    output logic [REG_AW-1:0] readReg2,
    output logic [REG_AW-1:0] writeReg,
    output logic              regWrite,
    output logic              writeEnable,
    output logic [3:0]        aluOp,
    output logic              aluSrc,
    output logic              memRead,
    output logic              memWrite,
    output logic              memToReg,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              jump,
    output logic [DATA_W-1:0] imm_ext,
    output logic [25:0]       jump_target,
    output logic              illegal,
    output logic [31:0]       retired
);

    stateT             state;
    logic [DATA_W-1:0] ir;
    logic [5:0]        opc;
    logic [5:0]        fn;
    logic [DATA_W-1:0] immNext;
    logic [REG_AW-1:0] dstNext;

    assign opc     = ir[31:26];
    assign fn      = ir[5:0];
    assign dstNext = (opc == OP_RTYPE) ? REG_AW'(ir[15:11]) : REG_AW'(ir[20:16]);

    imm_extend #(.DATA_W(DATA_W)) uImm (
        .opcode (opc),
        .imm    (ir[15:0]),
        .immExt (immNext)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            instr_ready <= 1'b0;
            readReg1    <= '0;
            readReg2    <= '0;
            writeReg    <= '0;
            regWrite    <= 1'b0;
            writeEnable <= 1'b0;
            aluOp       <= '0;
            aluSrc      <= 1'b0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            memToReg    <= 1'b0;
            branch_eq   <= 1'b0;
            branch_ne   <= 1'b0;
            jump        <= 1'b0;
            imm_ext     <= '0;
            jump_target <= '0;
            illegal     <= 1'b0;
            retired     <= '0;
        end else begin
            // Single-cycle strobes drop unless the transition below re-raises them.
            branch_eq   <= 1'b0;
            branch_ne   <= 1'b0;
            jump        <= 1'b0;
            regWrite    <= 1'b0;
            writeEnable <= 1'b0;
            case (state)
                S_IDLE: begin
                    // instr_ready is low for the first cycle after reset, so
                    // acceptance is gated on the registered flag.
                    if (instr_ready && instr_valid) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    readReg1    <= REG_AW'(ir[25:21]);
                    readReg2    <= REG_AW'(ir[20:16]);
                    writeReg    <= dstNext;
                    imm_ext     <= immNext;
                    aluOp       <= aluOpFor(opc, fn);
                    aluSrc      <= usesImm(opc);
                    jump_target <= ir[25:0];
                    memToReg    <= 1'b0;
                    if (!isLegal(opc, fn)) begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        branch_eq <= (opc == OP_BEQ);
                        branch_ne <= (opc == OP_BNE);
                        jump      <= (opc == OP_J);
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        OP_LW: begin
                            memRead <= 1'b1;
                            state   <= S_MEM;
                        end
                        OP_SW: begin
                            memWrite <= 1'b1;
                            state    <= S_MEM;
                        end
                        OP_BEQ, OP_BNE, OP_J: begin
                            instr_ready <= 1'b1;
                            retired     <= retired + 32'd1;
                            state       <= S_IDLE;
                        end
                        default: begin
                            writeEnable <= 1'b1;
                            regWrite    <= (writeReg != '0);
                            state       <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_done) begin
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                        if (opc == OP_LW) begin
                            memToReg    <= 1'b1;
                            writeEnable <= 1'b1;
                            regWrite    <= (writeReg != '0);
                            state       <= S_WB;
                        end else begin
                            instr_ready <= 1'b1;
                            retired     <= retired + 32'd1;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    memToReg    <= 1'b0;
                    instr_ready <= 1'b1;
                    retired     <= retired + 32'd1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Multi-cycle instruction decode and control sequencer for the unpipelined processor. Sits directly upstream of the `registers` block: accepts one instruction at a time from fetch and drives the register file's read/write addresses and write strobes. It also drives the ALU and memory control lines and a retired-instruction counter. All outputs are registered (Moore); one instruction is in flight at a time.

## Interface
- `DATA_W`, 32: instruction and immediate width.
- `REG_AW`, 5: register address width.
- `Clk` input 1: rising-edge clock.
- `Rst` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: fetch presents `instr`.
- `instr` input DATA_W: MIPS-format instruction word.
- `instr_ready` output 1: decoder can accept an instruction (IDLE only).
- `mem_done` input 1: data memory finished the current access.
- `readReg1` output REG_AW: rs field to register file.
- `readReg2` output REG_AW: rt field to register file.
- `writeReg` output REG_AW: destination (rd for R-type, rt for I-type).
- `regWrite` output 1: register write strobe, WB only, suppressed when `writeReg`==0.
- `writeEnable` output 1: register file write permit, high for every WB cycle.
- `aluOp` output 4: ALU operation code.
- `aluSrc` output 1: 1 selects `imm_ext` as the ALU B operand.
- `memRead`, `memWrite`, `memToReg` output 1 each: data memory controls.
- `branch_eq`, `branch_ne`, `jump` output 1 each: one-cycle pulses in EXEC.
- `imm_ext` output DATA_W: extended immediate.
- `jump_target` output 26: instr[25:0].
- `illegal` output 1: sticky unsupported-opcode flag.
- `retired` output 32: count of completed legal instructions.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE: `instr_ready`=1. If `instr_valid`, latch `instr` into IR and go to DECODE.
- DECODE:
  - Drive `readReg1`=IR[25:21] and `readReg2`=IR[20:16].
  - Compute `imm_ext`, `aluOp`, `aluSrc` and `writeReg`.
  - Illegal opcode or funct: set `illegal`, return to IDLE, leave `retired` unchanged.
  - Otherwise go to EXEC.
- EXEC:
  - lw/sw go to MEM.
  - R-type, addi, andi, ori and lui go to WB.
  - beq/bne/j pulse `branch_eq`/`branch_ne`/`jump`, go to IDLE, retire.
- MEM:
  - Hold `memRead` (lw) or `memWrite` (sw) until `mem_done`.
  - On `mem_done`: lw goes to WB with `memToReg`=1; sw goes to IDLE and retires.
- WB: assert `writeEnable` for one cycle; assert `regWrite` if `writeReg`≠0. Go to IDLE and retire.
- Supported instructions:
  - R-type (op 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type/J-type: addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Immediate extension:
  - Sign-extend IR[15:0] for addi, lw, sw, beq, bne.
  - Zero-extend for andi, ori.
  - lui: {IR[15:0],16'h0}.
- `aluOp` values: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5. lw/sw use ADD; beq/bne use SUB.
- `retired` wraps from 0xFFFFFFFF to 0. `illegal` clears only on reset.

## Timing
- Reset (Rst=0, any state, effective immediately):
  - State goes to IDLE.
  - All outputs are 0, including `instr_ready`, `retired` and `illegal`.
  - `instr_ready` rises on the first Clk edge after Rst release.
- Latency from acceptance edge to return to IDLE:
  - R-type and immediate ops: 4 cycles (DECODE, EXEC, WB, IDLE).
  - Branch/jump: 3 cycles.
  - lw: 5+k cycles, where k is the number of MEM cycles with `mem_done`=0. sw: 4+k.
- `mem_done` is sampled only in MEM. A `mem_done` asserted in the first MEM cycle gives k=0.
- `instr_valid` outside IDLE is ignored. `instr` must be stable only on the accepting edge.
- `readReg1`, `readReg2` and `writeReg` are valid from DECODE+1 and hold through WB, so register-file reads settle before WB.
- `retired` increments on the edge that enters IDLE from a legal instruction.

## Structure
- Shared package `cpu_pkg`: opcode/funct localparams, `aluOp` encodings, state encoding.
- Sub-module `imm_extend`: combinational immediate extension, selected by opcode.
- The FSM, IR and counter are inline in `decode_ctrl`.

## Test plan
- Reset mid-MEM: assert Rst=0 during a lw in MEM → all outputs 0 immediately; `instr_ready`=1 one edge after release; `retired`=0.
- add $10,$8,$9 (0x01095020) → `readReg1`=8, `readReg2`=9, `writeReg`=10, `aluOp`=0; `regWrite` high exactly in cycle 3 after acceptance; `retired`=1.
- addi $0,$1,-1 (0x2020FFFF) → `imm_ext`=0xFFFFFFFF, `aluSrc`=1; WB has `writeEnable`=1 and `regWrite`=0.
- lw $5,4($2) (0x8C450004) with `mem_done` delayed 3 cycles → `memRead` held 4 cycles, then WB with `writeReg`=5 and `memToReg`=1; total 8 cycles.
- ori $3,$3,0x8000 (0x34638000) → `imm_ext`=0x00008000. beq (0x10000003) → one `branch_eq` pulse, no WB.
- Illegal op 0x3F → `illegal`=1, return to IDLE after DECODE, `retired` unchanged; back-to-back `instr_valid` is accepted only while `instr_ready`=1.
